// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps MIDI note-on/off events onto NUM_VOICES slots by a serial scan.
// Optional feature: define VOICE_STEAL_EN to steal the oldest slot when a press finds no free slot.
module voice_alloc #(
  parameter int NUM_VOICES = 16,
  parameter int STAMP_W    = 8
) (
  input  logic       clk32,
  input  logic       rst,
  input  logic       note_pressed,
  input  logic       note_released,
  input  logic [6:0] note,
  input  logic [3:0] channel,
  input  logic [6:0] velocity,
  input  logic       voice_free,
  input  logic [7:0] voice_free_addr,
  output logic       o_note_pressed,
  output logic       o_note_released,
  output logic [6:0] o_note,
  output logic [3:0] o_channel,
  output logic [6:0] o_velocity,
  output logic [7:0] o_addr,
  output logic       busy,
  output logic       dropped
);

  localparam int AW = $clog2(NUM_VOICES);

  typedef struct packed {
    logic       rel;
    logic [6:0] note;
    logic [3:0] ch;
    logic [6:0] vel;
  } ev_t;

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

  state_t                                state;
  logic [NUM_VOICES-1:0]                 active, released;
  logic [NUM_VOICES-1:0][6:0]            s_note;
  logic [NUM_VOICES-1:0][3:0]            s_ch;
  logic [NUM_VOICES-1:0][STAMP_W-1:0]    s_stamp;
  logic [STAMP_W-1:0]                    stamp_ctr, best_age, age;
  logic                                  buf_vld, found, pop, in_vld, free_ok, hit, do_issue;
  ev_t                                   buf_ev, cur, in_ev;
  logic [AW-1:0]                         idx, sel, steal_idx, free_idx, tgt;

  assign in_vld   = note_pressed | note_released;
  // A simultaneous press and release is treated as a press.
  assign in_ev    = '{rel: ~note_pressed, note: note, ch: channel, vel: velocity};
  assign pop      = (state == IDLE) && buf_vld;
  assign busy     = (state != IDLE) || buf_vld;
  assign free_ok  = voice_free && ({1'b0, voice_free_addr} < 9'(NUM_VOICES));
  assign free_idx = voice_free_addr[AW-1:0];
  assign age      = stamp_ctr - s_stamp[idx];
  assign hit      = cur.rel ? (active[idx] && !released[idx] &&
                               s_note[idx] == cur.note && s_ch[idx] == cur.ch)
                            : !active[idx];

`ifdef VOICE_STEAL_EN
  assign do_issue = found | ~cur.rel;
  assign tgt      = found ? sel : steal_idx;
`else
  assign do_issue = found;
  assign tgt      = sel;
`endif

  always_ff @(posedge clk32) begin
    if (rst) begin
      state           <= IDLE;
      active          <= '0;
      released        <= '0;
      s_note          <= '0;
      s_ch            <= '0;
      s_stamp         <= '0;
      stamp_ctr       <= '0;
      buf_vld         <= 1'b0;
      buf_ev          <= '0;
      cur             <= '0;
      idx             <= '0;
      sel             <= '0;
      steal_idx       <= '0;
      best_age        <= '0;
      found           <= 1'b0;
      o_note_pressed  <= 1'b0;
      o_note_released <= 1'b0;
      o_note          <= '0;
      o_channel       <= '0;
      o_velocity      <= '0;
      o_addr          <= '0;
      dropped         <= 1'b0;
    end else begin
      o_note_pressed  <= 1'b0;
      o_note_released <= 1'b0;
      dropped         <= 1'b0;

      if (free_ok) begin
        active[free_idx]   <= 1'b0;
        released[free_idx] <= 1'b0;
      end

      // One-deep buffer; a slot opens up in the same cycle it is popped.
      if (in_vld) begin
        if (!buf_vld || pop) begin
          buf_vld <= 1'b1;
          buf_ev  <= in_ev;
        end else begin
          dropped <= 1'b1;
        end
      end else if (pop) begin
        buf_vld <= 1'b0;
      end

      case (state)
        IDLE: if (buf_vld) begin
          cur       <= buf_ev;
          idx       <= '0;
          found     <= 1'b0;
          best_age  <= '0;
          steal_idx <= '0;
          state     <= SCAN;
        end
        SCAN: begin
          if (hit && !found) begin
            found <= 1'b1;
            sel   <= idx;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (age > best_age) begin
            best_age  <= age;
            steal_idx <= idx;
          end
          if (idx == AW'(NUM_VOICES - 1)) state <= ISSUE;
          else                            idx   <= idx + 1'b1;
        end
        ISSUE: begin
          state <= IDLE;
          if (do_issue) begin
            o_note     <= cur.note;
            o_channel  <= cur.ch;
            o_velocity <= cur.vel;
            o_addr     <= 8'(tgt);
            if (cur.rel) begin
              o_note_released <= 1'b1;
              if (!(free_ok && free_idx == tgt)) released[tgt] <= 1'b1;
            end else begin
              // Written after the voice_free clear so a same-cycle claim wins.
              o_note_pressed <= 1'b1;
              active[tgt]    <= 1'b1;
              released[tgt]  <= 1'b0;
              s_note[tgt]    <= cur.note;
              s_ch[tgt]      <= cur.ch;
              s_stamp[tgt]   <= stamp_ctr;
              stamp_ctr      <= stamp_ctr + 1'b1;
            end
          end else begin
            dropped <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 16, number of voice slots managed (2..128, power of two).
REQ-002 SHALL have parameter STAMP_W, default 8, width of the allocation-age stamp.
REQ-003 SHALL have port clk32 input 1: single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-005 SHALL have port note_pressed input 1: MIDI note-on event pulse.
REQ-006 SHALL have port note_released input 1: MIDI note-off event pulse.
REQ-007 SHALL have port note input 7, channel input 4, velocity input 7: event payload, valid with either pulse.
REQ-008 SHALL have port voice_free input 1 and voice_free_addr input 8: pulse from the sample engine when a slot finished RELEASE and is silent.
REQ-009 SHALL have ports o_note_pressed output 1, o_note_released output 1: one-cycle event pulses to synth2.
REQ-010 SHALL have ports o_note output 7, o_channel output 4, o_velocity output 7, o_addr output 8: payload and slot address for synth2.
REQ-011 SHALL have port busy output 1: high while an event is being resolved.
REQ-012 SHALL have port dropped output 1: one-cycle pulse when an event is discarded.

Function
REQ-013 SHALL keep per slot: active flag, released flag, note, channel and an allocation stamp of STAMP_W bits.
REQ-014 SHALL use the FSM IDLE -> SCAN -> ISSUE -> IDLE. IDLE captures the event, SCAN visits slots 0..NUM_VOICES-1 one per cycle, and ISSUE drives the outputs.
REQ-015 SHALL handle a press as follows: select the lowest-index inactive slot. If none exists, apply REQ-027.
REQ-016 SHALL handle a release as follows: select the lowest-index slot that is active, not released, and has equal note and channel. If none exists, pulse dropped and issue nothing.
REQ-017 SHALL hold o_note_pressed or o_note_released high for exactly one cycle, starting NUM_VOICES+2 edges after the edge that sampled the input pulse.
REQ-018 SHALL hold the o_* payload stable from that pulse until the next issue.
REQ-019 SHALL, on issue of a press, set active=1, released=0, stamp=stamp_ctr, and increment stamp_ctr modulo 2^STAMP_W.
REQ-020 SHALL, on issue of a release, set released=1.
REQ-021 SHALL compute slot age as (stamp_ctr - stamp) modulo 2^STAMP_W, so that wrap-around is tolerated.
REQ-022 SHALL buffer one event that arrives while busy; busy = (state != IDLE) or buffer full.
REQ-023 SHALL, when an event arrives while the buffer is full, discard it and pulse dropped.
REQ-024 SHALL treat simultaneous press and release inputs as a press only.
REQ-025 SHALL clear active and released on voice_free in any state.
REQ-026 SHALL, when voice_free targets the slot being claimed in the same ISSUE cycle, let the claim win (slot stays active). voice_free_addr >= NUM_VOICES SHALL be ignored.

Configuration
REQ-027 SHALL support macro VOICE_STEAL_EN. When defined and no slot is free, a press takes the slot with the largest age, lowest index on ties. The slot is issued as a press: synth2 restarts it at BLANK.
REQ-028 SHALL, when VOICE_STEAL_EN is undefined, discard a press with no free slot and pulse dropped.

Reset
REQ-029 SHALL, on rst, clear all active and released flags and set stamp_ctr=0, state=IDLE and the buffer empty.
REQ-030 SHALL, on rst, drive o_note_pressed=0, o_note_released=0, o_note=0, o_channel=0, o_velocity=0, o_addr=0, busy=0 and dropped=0.
REQ-031 SHALL, when rst is asserted mid-SCAN, abort without issuing; buffered events are lost.

Verification
REQ-032 SHALL verify: after reset, press note 60 ch 0 vel 100 -> o_note_pressed pulse 18 edges later with o_addr=0, o_note=60, o_velocity=100.
REQ-033 SHALL verify: press 60, then press 62 at the following cycle -> issues at o_addr 0, then o_addr 1; busy high throughout; dropped stays 0.
REQ-034 SHALL verify: press 60 ch 0, then release 60 ch 1 -> dropped pulse and no issue; release 60 ch 0 -> o_note_released with o_addr=0.
REQ-035 SHALL verify: with 16 presses 40..55 issued, a 17th press 70 -> with VOICE_STEAL_EN, o_addr=0; without it, a dropped pulse.
REQ-036 SHALL verify: voice_free addr 3 after the fill -> next press gets o_addr=3. Run 300 presses with stamp wrap past 255 -> stealing still selects the oldest slot.
REQ-037 SHALL verify: rst during SCAN -> no output pulse, and the next press gets o_addr=0.
